rom_fetch_arbiter: RTL

- Shares one instruction ROM between two mest_pro cores (fetch ports 0 and 1).
- Arbitrates fetch requests round-robin, drives the synchronous ROM, and routes each returned instruction to the core that issued it.
- Sits between the cores' o_prog_counter/i_instruction interface and the single ROM macro.
- Fully pipelined: one ROM access per cycle in total, fixed 2-cycle accept-to-response latency.

---
 rtl/rom_fetch_arbiter_if.sv | 27 ++
 rtl/rom_fetch_arbiter.sv | 99 +++++++++
 2 files changed

// File: rtl/rom_fetch_arbiter_if.sv
// rtl/rom_fetch_arbiter_if.sv - fetch request/response and ROM bus bundle for rom_fetch_arbiter
interface rom_fetch_arbiter_if #(
    parameter int INSTRUCTION_SIZE = 28,
    parameter int AW               = 8
);
    logic [1:0]                  i_req_valid;
    logic [1:0]                  o_req_ready;
    logic [AW-1:0]               i_req_addr0;
    logic [AW-1:0]               i_req_addr1;
    logic [1:0]                  o_rsp_valid;
    logic [INSTRUCTION_SIZE-1:0] o_rsp_instr0;
    logic [INSTRUCTION_SIZE-1:0] o_rsp_instr1;
    logic                        o_rom_en;
    logic [AW-1:0]               o_rom_addr;
    logic [INSTRUCTION_SIZE-1:0] i_rom_data;

    // Environment side: the two cores plus the ROM macro.
    modport master (
        output i_req_valid, i_req_addr0, i_req_addr1, i_rom_data,
        input  o_req_ready, o_rsp_valid, o_rsp_instr0, o_rsp_instr1, o_rom_en, o_rom_addr
    );

    modport slave (
        input  i_req_valid, i_req_addr0, i_req_addr1, i_rom_data,
        output o_req_ready, o_rsp_valid, o_rsp_instr0, o_rsp_instr1, o_rom_en, o_rom_addr
    );
endinterface

// File: rtl/rom_fetch_arbiter.sv
// rtl/rom_fetch_arbiter.sv - round-robin two-port fetch arbiter in front of one synchronous instruction ROM
module rom_fetch_arbiter #(
    parameter int OP_CODE_SIZE     = 4,
    parameter int INSTRUCTION_SIZE = OP_CODE_SIZE + 8 + 8 + 8,
    parameter int ROM_DEPTH        = 256
) (
    input  logic              clk,
    input  logic              i_reset,
    rom_fetch_arbiter_if.slave bus
);
    localparam int AW = $clog2(ROM_DEPTH);

    logic                        grant_v;
    logic                        grant_id;

    logic                        prio_q, prio_d;
    logic                        tag_v_q, tag_v_d;
    logic                        tag_id_q, tag_id_d;
    logic [1:0]                  rsp_valid_q, rsp_valid_d;
    logic [INSTRUCTION_SIZE-1:0] rsp_instr0_q, rsp_instr0_d;
    logic [INSTRUCTION_SIZE-1:0] rsp_instr1_q, rsp_instr1_d;

    // Grant is suppressed during reset so nothing reaches the ROM or the tag pipe.
    always_comb begin
        grant_v  = 1'b0;
        grant_id = 1'b0;
        if (!i_reset) begin
            case (bus.i_req_valid)
                2'b01: begin
                    grant_v  = 1'b1;
                    grant_id = 1'b0;
                end
                2'b10: begin
                    grant_v  = 1'b1;
                    grant_id = 1'b1;
                end
                2'b11: begin
                    grant_v  = 1'b1;
                    grant_id = prio_q;
                end
                default: begin
                    grant_v  = 1'b0;
                    grant_id = 1'b0;
                end
            endcase
        end
    end

    assign bus.o_req_ready = {grant_v & grant_id, grant_v & ~grant_id};
    assign bus.o_rom_en    = grant_v;

    always_comb begin
        bus.o_rom_addr = '0;
        if (grant_v) begin
            bus.o_rom_addr = grant_id ? bus.i_req_addr1[AW-1:0] : bus.i_req_addr0[AW-1:0];
        end
    end

    always_comb begin
        prio_d       = grant_v ? ~grant_id : prio_q;
        tag_v_d      = grant_v;
        tag_id_d     = grant_id;
        rsp_valid_d  = 2'b00;
        rsp_instr0_d = rsp_instr0_q;
        rsp_instr1_d = rsp_instr1_q;
        // ROM data is valid exactly one cycle after its enable, which is when tag_v_q is set.
        if (tag_v_q) begin
            if (tag_id_q) begin
                rsp_valid_d  = 2'b10;
                rsp_instr1_d = bus.i_rom_data;
            end else begin
                rsp_valid_d  = 2'b01;
                rsp_instr0_d = bus.i_rom_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            prio_q       <= 1'b0;
            tag_v_q      <= 1'b0;
            tag_id_q     <= 1'b0;
            rsp_valid_q  <= 2'b00;
            rsp_instr0_q <= '0;
            rsp_instr1_q <= '0;
        end else begin
            prio_q       <= prio_d;
            tag_v_q      <= tag_v_d;
            tag_id_q     <= tag_id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_instr0_q <= rsp_instr0_d;
            rsp_instr1_q <= rsp_instr1_d;
        end
    end

    assign bus.o_rsp_valid  = rsp_valid_q;
    assign bus.o_rsp_instr0 = rsp_instr0_q;
    assign bus.o_rsp_instr1 = rsp_instr1_q;
endmodule
